// File: rtl/decoder_pkg.sv
// decoder_pkg: shared types and constants for decoder_nbit_seq.
//   state_t - controller state encoding (IDLE, DIRECT, SCAN)
//   ACTIVE_LOW / D_IDLE - polarity of the d outputs and the per-line value
//                         d shows in reset, IDLE and when disabled
// Configuration macro: DECODER_ACTIVE_LOW_EN (defined -> d is active-low).
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

`ifdef DECODER_ACTIVE_LOW_EN
    localparam logic ACTIVE_LOW = 1'b1;
`else
    localparam logic ACTIVE_LOW = 1'b0;
`endif

    // Per-line idle value; replicated to the full output width by users.
    localparam logic D_IDLE = ACTIVE_LOW;

endpackage

// File: rtl/decoder_nbit_seq_onehot_dec.sv
// onehot_dec: combinational N-to-2^N one-hot decoder (active-high).
//   sel  [N-1:0]    - index to decode
//   line [2^N-1:0]  - exactly one bit set, at position sel
// Polarity (DECODER_ACTIVE_LOW_EN) is applied by the instantiating module.
module onehot_dec #(
    parameter int N = 2
) (
    input  logic [N-1:0]      sel,
    output logic [2**N-1:0]   line
);

    always_comb begin
        line      = '0;
        line[sel] = 1'b1;
    end

endmodule

// File: rtl/decoder_nbit_seq.sv
// decoder_nbit_seq: registered N-to-2^N one-hot decoder with direct and
// scan modes.
//   clk, rst_n      - clock, asynchronous active-low reset
//   en              - block enable; 0 returns to IDLE and clears outputs
//   mode            - 0 direct, 1 scan; only looked at in IDLE
//   a, in_valid     - address / scan seed and its valid
//   in_ready        - combinational accept indication
//   dwell           - cycles-minus-one per scan index, captured at seed
//   d               - registered one-hot decode
//   out_valid       - d holds a decoded value
//   scan_wrap       - 1-cycle pulse when the scan index wraps to 0
// Configuration macro: DECODER_ACTIVE_LOW_EN (defined -> d is active-low).
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | outputs cleared; waits for en, branches on mode
// DIRECT | each accepted a is decoded onto d with 1-cycle latency
// SCAN   | d steps through all lines, each held for dwell+1 cycles
module decoder_nbit_seq
    import decoder_pkg::*;
#(
    parameter int N       = 2,
    parameter int DWELL_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 mode,
    input  logic [N-1:0]         a,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DWELL_W-1:0]   dwell,
    output logic [2**N-1:0]      d,
    output logic                 out_valid,
    output logic                 scan_wrap
);

    localparam int LINES = 2**N;
    localparam logic [LINES-1:0] D_IDLE_VEC = {LINES{D_IDLE}};

    state_t               state;
    logic [N-1:0]         idx;
    logic [N-1:0]         idx_inc;
    logic [N-1:0]         dec_sel;
    logic [DWELL_W-1:0]   dwell_cnt;
    logic [DWELL_W-1:0]   dwell_cap;
    logic [LINES-1:0]     dec_line;
    logic [LINES-1:0]     d_line;
    logic                 handshake;

    assign in_ready  = en && ((state == DIRECT) || ((state == IDLE) && mode));
    assign handshake = in_valid && in_ready;

    assign idx_inc = idx + N'(1);

    // In SCAN the only thing ever loaded into d is the next index; in the
    // other states it is the incoming address.
    assign dec_sel = (state == SCAN) ? idx_inc : a;

    onehot_dec #(.N(N)) u_onehot_dec (
        .sel  (dec_sel),
        .line (dec_line)
    );

    // D_IDLE_VEC is all ones exactly when active-low, so XOR applies polarity.
    assign d_line = dec_line ^ D_IDLE_VEC;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            d         <= D_IDLE_VEC;
            out_valid <= 1'b0;
            scan_wrap <= 1'b0;
            idx       <= '0;
            dwell_cnt <= '0;
            dwell_cap <= '0;
        end else if (!en) begin
            state     <= IDLE;
            d         <= D_IDLE_VEC;
            out_valid <= 1'b0;
            scan_wrap <= 1'b0;
            idx       <= '0;
            dwell_cnt <= '0;
            dwell_cap <= '0;
        end else begin
            scan_wrap <= 1'b0;
            case (state)
                IDLE: begin
                    if (!mode) begin
                        state <= DIRECT;
                    end else if (handshake) begin
                        state     <= SCAN;
                        idx       <= a;
                        dwell_cnt <= dwell;
                        dwell_cap <= dwell;
                        d         <= d_line;
                        out_valid <= 1'b1;
                    end
                end
                DIRECT: begin
                    if (handshake) begin
                        d         <= d_line;
                        out_valid <= 1'b1;
                    end
                end
                SCAN: begin
                    if (dwell_cnt != '0) begin
                        dwell_cnt <= dwell_cnt - DWELL_W'(1);
                    end else begin
                        idx       <= idx_inc;
                        dwell_cnt <= dwell_cap;
                        d         <= d_line;
                        // Only an advance onto 0 pulses, so a seed of 0 never does.
                        scan_wrap <= (idx_inc == '0);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/decoder_nbit_seq.md
Name: decoder_nbit_seq

Overview:
Parametrised, registered N-to-2^N one-hot decoder. It is the next generation of the team's 2-to-4 enable decoder. Two modes:
- Direct mode: decodes handshaken addresses with 1-cycle latency.
- Scan mode: steps the active output through all 2^N lines with a programmable dwell time.

It sits between control logic and line-select/strobe consumers, such as mux selects and display digit enables.

Parameters:
N, 2, address width; output width is 2^N.
DWELL_W, 4, width of the dwell-time field.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  block enable; 0 forces IDLE and clears outputs
mode  input  1  0 = direct, 1 = scan; sampled only in IDLE
a  input  N  address (direct) or start index (scan seed)
in_valid  input  1  a is valid
in_ready  output  1  block accepts a this cycle
dwell  input  DWELL_W  cycles-minus-one each index is held in scan; captured at seed
d  output  2^N  registered one-hot decode
out_valid  output  1  d holds a decoded value
scan_wrap  output  1  1-cycle pulse when scan index wraps to 0

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values (immediate on rst_n=0, including mid-scan): state=IDLE, d=0, out_valid=0, scan_wrap=0, idx=0, dwell_cnt=0.
- States: IDLE, DIRECT, SCAN.
- in_ready (combinational):
  - 1 in DIRECT when en=1.
  - 1 in IDLE when en=1 and mode=1.
  - 0 otherwise, including throughout SCAN.
- Handshake: a is accepted when in_valid && in_ready.
- IDLE:
  - en=1, mode=0 -> DIRECT next cycle; d stays 0.
  - en=1, mode=1, handshake -> SCAN next cycle. Capture idx=a and dwell_cnt=dwell. Next cycle d=onehot(a), out_valid=1.
  - en=0 -> stay IDLE.
- DIRECT:
  - On handshake, next cycle d=onehot(a) and out_valid=1.
  - Without a handshake, d and out_valid hold their values.
  - mode changes are ignored until the block re-enters IDLE.
- SCAN:
  - Each cycle with dwell_cnt!=0: dwell_cnt decrements.
  - When dwell_cnt==0: idx <= idx+1 mod 2^N, dwell_cnt <= captured dwell, d <= onehot(idx+1).
  - Result: each index is shown for dwell+1 cycles. dwell=0 advances every cycle.
  - scan_wrap=1 in exactly the first cycle that d shows index 0 after advancing from 2^N-1. A seed of a=0 does not pulse.
- en=0 in any state: next cycle state=IDLE, d=0, out_valid=0, scan_wrap=0. Captured idx and dwell are discarded.
- All outputs are registered, except in_ready.
- d is always either 0 or exactly one bit set. No glitch-free guarantee is needed beyond registering.

Optional Feature:
Macro DECODER_ACTIVE_LOW_EN.
- Defined: d is emitted inverted (active-low, 74x139 style). Reset, IDLE and disabled value is all ones; the selected line is 0.
- Undefined: active-high as described above.
- out_valid, scan_wrap and in_ready are unaffected by the macro.

Decomposition:
- Package decoder_pkg:
  - state enum (IDLE, DIRECT, SCAN)
  - a parametrised onehot function or constant helper
  - the D_IDLE constant (0 or all-ones, selected by the macro)
- One sub-module is natural: onehot_dec, a combinational N-to-2^N decoder instantiated for the d next-state value. Everything else stays in decoder_nbit_seq.

Test Plan (N=2, DWELL_W=4):
1. Reset: assert rst_n=0 mid-scan -> d=0000, out_valid=0, scan_wrap=0 without waiting for a clock edge. Release -> remain IDLE while en=0.
2. Direct: en=1, mode=0, wait 1 cycle. a=2 with in_valid -> next cycle d=0100, out_valid=1. Then a=3 -> 1000. Then in_valid=0 for 5 cycles -> d holds 1000.
3. Scan: en=1, mode=1, a=1, dwell=2, in_valid 1 cycle -> d=0010 for 3 cycles, 0100 x3, 1000 x3, 0001 x3 with scan_wrap=1 only in the first 0001 cycle, then 0010. in_ready=0 throughout.
4. Scan dwell=0, seed a=3 -> d=1000, 0001 (scan_wrap=1), 0010, 0100, 1000 on consecutive cycles.
5. Disable mid-scan: drop en during the second 0100 cycle -> next cycle d=0000, out_valid=0, in_ready=0, state IDLE. Re-enable with mode=0 -> DIRECT.
6. With DECODER_ACTIVE_LOW_EN defined, repeat scenario 2 -> d=1111 in reset/IDLE, then 1011, then 0111.
